// File: rtl/execute_arbiter_if.sv
// Request/response bundle between two requesters and the shared execute arbiter.
// Requester i owns bit i of every 2-bit field and slice i of every packed operand field.
interface execute_arbiter_if #(
    parameter int unsigned N = 64
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_alusrc;
    logic [7:0]     req_aluctl;
    logic [2*N-1:0] req_pc;
    logic [2*N-1:0] req_imm;
    logic [2*N-1:0] req_rd1;
    logic [2*N-1:0] req_rd2;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [N-1:0]   rsp_pcbranch;
    logic [N-1:0]   rsp_alures;
    logic [N-1:0]   rsp_wdata;
    logic           rsp_zero;
    logic           busy;

    // Requester side
    modport master (
        output req_valid, req_alusrc, req_aluctl, req_pc, req_imm, req_rd1, req_rd2, rsp_ready,
        input  req_ready, rsp_valid, rsp_pcbranch, rsp_alures, rsp_wdata, rsp_zero, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_alusrc, req_aluctl, req_pc, req_imm, req_rd1, req_rd2, rsp_ready,
        output req_ready, rsp_valid, rsp_pcbranch, rsp_alures, rsp_wdata, rsp_zero, busy
    );
endinterface

// File: rtl/execute_arbiter.sv
// Shares one execute datapath (ALU + branch adder) between two requesters.
// Round-robin grant, operands latched on acceptance, response held until the owner takes it.
module execute_arbiter #(
    parameter int unsigned N = 64
) (
    input  logic        clk,
    input  logic        reset,
    execute_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    // ALU control encodings understood by the execute datapath
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    state_e       state_q, state_d;
    logic         grant_q, grant_d;
    logic         last_grant_q, last_grant_d;
    logic         sel;
    logic         accept;

    logic         op_alusrc_q;
    logic [3:0]   op_aluctl_q;
    logic [N-1:0] op_pc_q, op_imm_q, op_rd1_q, op_rd2_q;

    logic [N-1:0] rsp_pcbranch_q, rsp_alures_q, rsp_wdata_q;
    logic         rsp_zero_q;

    logic [N-1:0] alu_b;
    logic [N-1:0] ex_pcbranch, ex_alures, ex_wdata;
    logic         ex_zero;
    logic         slt;

    // Grant candidate: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        sel = bus.req_valid[1];
        if (&bus.req_valid) begin
            sel = ~last_grant_q;
        end
    end

    // FSM next-state, acceptance and grant bookkeeping
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    accept  = 1'b1;
                    grant_d = sel;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, grant owner and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Operand registers: the datapath only ever sees these latched copies
    always_ff @(posedge clk) begin
        if (reset) begin
            op_alusrc_q <= 1'b0;
            op_aluctl_q <= 4'b0;
            op_pc_q     <= '0;
            op_imm_q    <= '0;
            op_rd1_q    <= '0;
            op_rd2_q    <= '0;
        end else if (accept) begin
            op_alusrc_q <= sel ? bus.req_alusrc[1] : bus.req_alusrc[0];
            op_aluctl_q <= sel ? bus.req_aluctl[7:4] : bus.req_aluctl[3:0];
            op_pc_q     <= sel ? bus.req_pc[2*N-1:N]  : bus.req_pc[N-1:0];
            op_imm_q    <= sel ? bus.req_imm[2*N-1:N] : bus.req_imm[N-1:0];
            op_rd1_q    <= sel ? bus.req_rd1[2*N-1:N] : bus.req_rd1[N-1:0];
            op_rd2_q    <= sel ? bus.req_rd2[2*N-1:N] : bus.req_rd2[N-1:0];
        end
    end

    // Execute datapath: ALU, branch target adder, store-data passthrough
    always_comb begin
        alu_b       = op_alusrc_q ? op_imm_q : op_rd2_q;
        slt         = $signed(op_rd1_q) < $signed(alu_b);
        ex_alures   = '0;
        case (op_aluctl_q)
            AluAnd:  ex_alures = op_rd1_q & alu_b;
            AluOr:   ex_alures = op_rd1_q | alu_b;
            AluAdd:  ex_alures = op_rd1_q + alu_b;
            AluSub:  ex_alures = op_rd1_q - alu_b;
            AluSlt:  ex_alures = {{(N-1){1'b0}}, slt};
            AluNor:  ex_alures = ~(op_rd1_q | alu_b);
            default: ex_alures = '0;
        endcase
        ex_zero     = (ex_alures == '0);
        ex_pcbranch = op_pc_q + (op_imm_q << 2);
        ex_wdata    = op_rd2_q;
    end

    // Response registers: captured once in EXEC, held stable through RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pcbranch_q <= '0;
            rsp_alures_q   <= '0;
            rsp_wdata_q    <= '0;
            rsp_zero_q     <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_pcbranch_q <= ex_pcbranch;
            rsp_alures_q   <= ex_alures;
            rsp_wdata_q    <= ex_wdata;
            rsp_zero_q     <= ex_zero;
        end
    end

    // Handshake outputs; req_ready is suppressed while reset is held
    always_comb begin
        bus.req_ready    = (accept && !reset) ? {sel, ~sel} : 2'b00;
        bus.rsp_valid    = (state_q == StResp) ? {grant_q, ~grant_q} : 2'b00;
        bus.busy         = (state_q != StIdle);
        bus.rsp_pcbranch = rsp_pcbranch_q;
        bus.rsp_alures   = rsp_alures_q;
        bus.rsp_wdata    = rsp_wdata_q;
        bus.rsp_zero     = rsp_zero_q;
    end

endmodule
